// File: rtl/doorlock_sequencer.sv
// -----------------------------------------------------------------------------
// doorlock_sequencer
//
// Sequences the keypad door lock around an external pair of password
// comparators. Keypad digits are shifted into the 128-bit entry buffer
// (input_value), one nibble per digit. On confirm, the comparator results
// (same / master_same) are sampled one cycle later, and the block then either
// opens the door for OPEN_CYCLES cycles, enters password-programming mode
// (master password), or records a failed attempt. MAX_FAIL consecutive failures
// start a LOCK_CYCLES lockout. The user password register (ans) lives here and
// is reprogrammed from the entry buffer while in programming mode.
//
// Ports:
//   clk          in   1    system clock, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   key_valid    in   1    one-cycle strobe, key_code valid
//   key_code     in   4    digit 0-9; codes 10-15 are ignored
//   confirm      in   1    one-cycle strobe, submit entry
//   clear        in   1    one-cycle strobe, discard entry
//   same         in   1    comparator result: input_value == ans
//   master_same  in   1    comparator result: input_value == master_ans
//   input_value  out  128  entry buffer to the comparators
//   ans          out  128  stored user password to the comparators
//   unlock       out  1    door open
//   fail         out  1    one-cycle pulse on a wrong attempt
//   locked       out  1    high during lockout
//   set_mode     out  1    high while awaiting a new password
//   fail_cnt     out  4    current consecutive failure count
// -----------------------------------------------------------------------------
module doorlock_sequencer #(
    parameter int unsigned   MAX_FAIL    = 3,
    parameter int unsigned   OPEN_CYCLES = 16,
    parameter int unsigned   LOCK_CYCLES = 64,
    parameter logic [127:0]  DEFAULT_ANS = 128'h1234
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         confirm,
    input  logic         clear,
    input  logic         same,
    input  logic         master_same,
    output logic [127:0] input_value,
    output logic [127:0] ans,
    output logic         unlock,
    output logic         fail,
    output logic         locked,
    output logic         set_mode,
    output logic [3:0]   fail_cnt
);

    localparam logic [2:0] ST_ENTRY   = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_LOCKOUT = 3'd3;
    localparam logic [2:0] ST_SET_NEW = 3'd4;

    // One down-counter serves both the open window and the lockout window,
    // so it is sized for the longer of the two.
    localparam int unsigned TIMER_MAX = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
    localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    logic [2:0]         state;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         fail_next;

    assign fail_next = fail_cnt + 4'd1;

    // NOTE: every register below is written with non-blocking assignments so
    // that all reads in this block see the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ENTRY;
            input_value <= '0;
            // NOTE: ans is a plain register, not a RAM, so it is reset like
            // any other state and reverts to DEFAULT_ANS on every reset.
            ans         <= DEFAULT_ANS;
            unlock      <= 1'b0;
            fail        <= 1'b0;
            locked      <= 1'b0;
            set_mode    <= 1'b0;
            fail_cnt    <= 4'd0;
            timer       <= '0;
        end else begin
            // fail is a single-cycle pulse; only CHECK raises it.
            fail <= 1'b0;

            case (state)
                ST_ENTRY, ST_SET_NEW: begin
                    // Priority: confirm, then clear, then a digit.
                    if (confirm) begin
                        if (state == ST_ENTRY) begin
                            // Buffer is kept so the comparators can settle on it
                            // during CHECK.
                            state <= ST_CHECK;
                        end else begin
                            // An empty entry leaves the stored password alone.
                            if (input_value != '0) begin
                                ans <= input_value;
                            end
                            input_value <= '0;
                            set_mode    <= 1'b0;
                            state       <= ST_ENTRY;
                        end
                    end else if (clear) begin
                        input_value <= '0;
                    end else if (key_valid && (key_code <= 4'd9)) begin
                        // Oldest digit falls off the top: the last 32 digits are kept.
                        input_value <= {input_value[123:0], key_code};
                    end
                end

                ST_CHECK: begin
                    input_value <= '0;
                    if (master_same) begin
                        set_mode <= 1'b1;
                        fail_cnt <= 4'd0;
                        state    <= ST_SET_NEW;
                    end else if (same) begin
                        unlock   <= 1'b1;
                        fail_cnt <= 4'd0;
                        timer    <= TIMER_W'(OPEN_CYCLES - 1);
                        state    <= ST_OPEN;
                    end else begin
                        fail <= 1'b1;
                        if (fail_next == 4'(MAX_FAIL)) begin
                            locked   <= 1'b1;
                            fail_cnt <= 4'd0;
                            timer    <= TIMER_W'(LOCK_CYCLES - 1);
                            state    <= ST_LOCKOUT;
                        end else begin
                            fail_cnt <= fail_next;
                            state    <= ST_ENTRY;
                        end
                    end
                end

                ST_OPEN: begin
                    // Timer is loaded with N-1 so the output is high N cycles.
                    if (timer == '0) begin
                        unlock <= 1'b0;
                        state  <= ST_ENTRY;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    if (timer == '0) begin
                        locked <= 1'b0;
                        state  <= ST_ENTRY;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a clean idle state.
                    unlock      <= 1'b0;
                    locked      <= 1'b0;
                    set_mode    <= 1'b0;
                    input_value <= '0;
                    state       <= ST_ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_doorlock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_doorlock_sequencer
//
// Self-checking bench for doorlock_sequencer. The comparators are modelled by
// two equality tests on the DUT outputs. A behavioural model tracks the lock
// as a phase plus a count of remaining cycles and predicts every output; a
// compare process checks it against the DUT each cycle. Directed scenarios
// carry hand-computed literal expectations, then random keypad traffic runs.
// -----------------------------------------------------------------------------
module tb_doorlock_sequencer;

    localparam int unsigned  MAX_FAIL    = 3;
    localparam int unsigned  OPEN_CYCLES = 16;
    localparam int unsigned  LOCK_CYCLES = 64;
    localparam logic [127:0] DEFAULT_ANS = 128'h1234;
    localparam logic [127:0] MASTER_ANS  = 128'h2580;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         confirm;
    logic         clear;
    logic         same;
    logic         master_same;
    logic [127:0] input_value;
    logic [127:0] ans;
    logic         unlock;
    logic         fail;
    logic         locked;
    logic         set_mode;
    logic [3:0]   fail_cnt;

    int n_total = 0;
    int n_pass  = 0;

    doorlock_sequencer #(
        .MAX_FAIL    (MAX_FAIL),
        .OPEN_CYCLES (OPEN_CYCLES),
        .LOCK_CYCLES (LOCK_CYCLES),
        .DEFAULT_ANS (DEFAULT_ANS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .confirm     (confirm),
        .clear       (clear),
        .same        (same),
        .master_same (master_same),
        .input_value (input_value),
        .ans         (ans),
        .unlock      (unlock),
        .fail        (fail),
        .locked      (locked),
        .set_mode    (set_mode),
        .fail_cnt    (fail_cnt)
    );

    // Comparator block stand-in.
    assign same        = (input_value == ans);
    assign master_same = (input_value == MASTER_ANS);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef enum int {M_IDLE, M_CHECK, M_OPEN, M_LOCK, M_SET} phase_t;

    phase_t       m_phase;
    logic [127:0] m_buf;
    logic [127:0] m_ans;
    int           m_fails;
    int           m_left;   // cycles still to spend in OPEN / LOCK
    logic         m_pulse;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= M_IDLE;
            m_buf   <= '0;
            m_ans   <= DEFAULT_ANS;
            m_fails <= 0;
            m_left  <= 0;
            m_pulse <= 1'b0;
        end else begin
            m_pulse <= 1'b0;
            case (m_phase)
                M_IDLE, M_SET: begin
                    if (confirm) begin
                        if (m_phase == M_IDLE) begin
                            m_phase <= M_CHECK;
                        end else begin
                            if (m_buf != 0) m_ans <= m_buf;
                            m_buf   <= '0;
                            m_phase <= M_IDLE;
                        end
                    end else if (clear) begin
                        m_buf <= '0;
                    end else if (key_valid && key_code < 10) begin
                        m_buf <= m_buf * 16 + 128'(key_code);
                    end
                end
                M_CHECK: begin
                    m_buf <= '0;
                    if (m_buf == MASTER_ANS) begin
                        m_phase <= M_SET;
                        m_fails <= 0;
                    end else if (m_buf == m_ans) begin
                        m_phase <= M_OPEN;
                        m_left  <= OPEN_CYCLES;
                        m_fails <= 0;
                    end else begin
                        m_pulse <= 1'b1;
                        if (m_fails + 1 == MAX_FAIL) begin
                            m_phase <= M_LOCK;
                            m_left  <= LOCK_CYCLES;
                            m_fails <= 0;
                        end else begin
                            m_phase <= M_IDLE;
                            m_fails <= m_fails + 1;
                        end
                    end
                end
                default: begin
                    if (m_left == 1) m_phase <= M_IDLE;
                    m_left <= m_left - 1;
                end
            endcase
        end
    end

    // Outputs settle after the rising edge; compare on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("input_value", input_value, m_buf);
            check("ans", ans, m_ans);
            check("unlock", 128'(unlock), 128'(m_phase == M_OPEN));
            check("locked", 128'(locked), 128'(m_phase == M_LOCK));
            check("set_mode", 128'(set_mode), 128'(m_phase == M_SET));
            check("fail", 128'(fail), 128'(m_pulse));
            check("fail_cnt", 128'(fail_cnt), 128'(m_fails));
        end
    end

    // ------------------------------------------------------------- stimulus
    // All tasks start and end on a falling edge.
    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_code  = d;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic do_confirm();
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic type_value(input logic [127:0] v);
        int top;
        top = -1;
        for (int i = 0; i < 32; i++) if (v[i*4 +: 4] != 4'd0) top = i;
        for (int i = top; i >= 0; i--) press(v[i*4 +: 4]);
    endtask

    task automatic count_high_unlock(output int cnt);
        cnt = 0;
        for (int g = 0; g < 200 && unlock; g++) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        logic [127:0] all_ones;
        all_ones  = {32{4'h1}};
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        confirm   = 1'b0;
        clear     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ans", ans, 128'h1234);
        check("reset_unlock", 128'(unlock), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct password: unlock appears two cycles after confirm, for 16 cycles.
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("entry_1234", input_value, 128'h1234);
        do_confirm();
        check("unlock_not_yet", 128'(unlock), 128'd0);
        @(negedge clk);
        check("unlock_latency", 128'(unlock), 128'd1);
        count_high_unlock(cnt);
        check("unlock_cycles", 128'(cnt), 128'd16);
        check("fail_cnt_after_open", 128'(fail_cnt), 128'd0);

        // Three wrong attempts lead to lockout; keys during lockout are ignored.
        for (int k = 1; k <= 3; k++) begin
            press(4'd9); press(4'd9);
            do_confirm();
            @(negedge clk);
            check("fail_pulse", 128'(fail), 128'd1);
            check("fail_cnt_step", 128'(fail_cnt), 128'((k < 3) ? k : 0));
            check("locked_step", 128'(locked), 128'(k == 3));
        end
        cnt = 0;
        for (int g = 0; g < 200 && locked; g++) begin
            cnt++;
            key_valid = 1'b1;
            key_code  = 4'($urandom_range(0, 9));
            @(negedge clk);
        end
        key_valid = 1'b0;
        check("locked_cycles", 128'(cnt), 128'd64);
        check("lockout_buffer", input_value, 128'h0);

        // Master password, then reprogram to 567 and open with it.
        type_value(MASTER_ANS);
        do_confirm();
        @(negedge clk);
        check("set_mode_on", 128'(set_mode), 128'd1);
        press(4'd5); press(4'd6); press(4'd7);
        do_confirm();
        check("ans_567", ans, 128'h567);
        check("set_mode_off", 128'(set_mode), 128'd0);
        press(4'd5); press(4'd6); press(4'd7);
        do_confirm();
        @(negedge clk);
        check("unlock_new_ans", 128'(unlock), 128'd1);
        repeat (20) @(negedge clk);

        // Empty confirm in programming mode keeps the password.
        type_value(MASTER_ANS);
        do_confirm();
        @(negedge clk);
        do_confirm();
        check("empty_set_keeps_ans", ans, 128'h567);
        check("empty_set_exits", 128'(set_mode), 128'd0);

        // Clear, ignored codes, and clear winning over a digit.
        press(4'd1); press(4'd2);
        do_clear();
        press(4'd3);
        check("clear_then_3", input_value, 128'h3);
        press(4'd12);
        check("code_12_ignored", input_value, 128'h3);
        key_valid = 1'b1; key_code = 4'd5; clear = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; clear = 1'b0;
        check("clear_wins", input_value, 128'h0);

        // 33 digits: the oldest one falls off.
        for (int i = 0; i < 33; i++) press(4'd1);
        check("buffer_33_ones", input_value, all_ones);
        do_clear();

        // Reset during OPEN.
        press(4'd5); press(4'd6); press(4'd7);
        do_confirm();
        @(negedge clk);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_open_unlock", 128'(unlock), 128'd0);
        check("rst_open_ans", ans, 128'h1234);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in programming mode after a password change.
        type_value(MASTER_ANS);
        do_confirm();
        @(negedge clk);
        press(4'd4); press(4'd2);
        do_confirm();
        check("ans_42", ans, 128'h42);
        type_value(MASTER_ANS);
        do_confirm();
        @(negedge clk);
        press(4'd3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_set_mode", 128'(set_mode), 128'd0);
        check("rst_set_ans", ans, 128'h1234);
        check("rst_set_buffer", input_value, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        type_value(128'h1234);
        do_confirm();
        @(negedge clk);
        check("unlock_after_reset", 128'(unlock), 128'd1);
        repeat (20) @(negedge clk);

        // Random keypad traffic against the model.
        for (int it = 0; it < 2500; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r <= 11) begin
                key_valid = 1'b1;
                key_code  = 4'($urandom_range(0, 15));
                clear     = ($urandom_range(0, 15) == 0);
                confirm   = ($urandom_range(0, 31) == 0);
                @(negedge clk);
                key_valid = 1'b0; clear = 1'b0; confirm = 1'b0;
            end else if (r == 12) begin
                do_clear();
            end else if (r <= 15) begin
                do_confirm();
            end else if (r <= 17) begin
                type_value(m_ans);
                do_confirm();
            end else if (r == 18) begin
                type_value(MASTER_ANS);
                do_confirm();
            end else begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
